// File: rtl/button_debounce_pkg.sv
// Shared helpers for the button debouncer: default timing and counter sizing.
package button_debounce_pkg;

  // 20 ms at a 50 MHz system clock.
  localparam int DEFAULT_DELAY_COUNTS = 1_000_000;

  // Counter width must hold DELAY_COUNTS-1 and is never narrower than one bit.
  function automatic int cnt_width(input int counts);
    int w;
    w = $clog2(counts);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_debounce_sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs, cleared to 0 on reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    // Each bit gets its own independent two-stage metastability filter.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_reg[gi] <= 1'b0;
        sync2_reg[gi] <= 1'b0;
      end else begin
        sync1_reg[gi] <= d[gi];
        sync2_reg[gi] <= sync1_reg[gi];
      end
    end
  end

  assign q = sync2_reg;

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: synchronises the raw level, requires DELAY_COUNTS
// consecutive disagreeing cycles before the clean level flips, and emits
// one-cycle press/release strobes on the same edge the clean level changes.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int DELAY_COUNTS = DEFAULT_DELAY_COUNTS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic button_pressed,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int              CNT_W   = cnt_width(DELAY_COUNTS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DELAY_COUNTS - 1);

  logic             sync2;
  logic [CNT_W-1:0] cnt_reg;
  logic             pressed_reg;
  logic             press_pulse_reg;
  logic             release_pulse_reg;
  logic             disagree;
  logic             at_limit;

  sync_2ff #(
    .WIDTH (1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (button),
    .q     (sync2)
  );

  assign disagree = (sync2 != pressed_reg);
  assign at_limit = (cnt_reg == CNT_MAX);

  // Count consecutive disagreeing cycles; any agreeing cycle discards the run.
  // The clean level and its strobe update together when the run completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg           <= '0;
      pressed_reg       <= 1'b0;
      press_pulse_reg   <= 1'b0;
      release_pulse_reg <= 1'b0;
    end else begin
      press_pulse_reg   <= 1'b0;
      release_pulse_reg <= 1'b0;
      if (!disagree) begin
        cnt_reg <= '0;
      end else if (at_limit) begin
        cnt_reg           <= '0;
        pressed_reg       <= sync2;
        press_pulse_reg   <= sync2;
        release_pulse_reg <= ~sync2;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign button_pressed = pressed_reg;
  assign press_pulse    = press_pulse_reg;
  assign release_pulse  = release_pulse_reg;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DELAY_COUNTS = 4 and a 20 ns clock.
module tb_button_debounce;

  logic clk;
  logic rst_n;
  logic button;
  logic button_pressed;
  logic press_pulse;
  logic release_pulse;

  int checks;
  int failures;
  int press_cnt;
  int release_cnt;

  button_debounce #(
    .DELAY_COUNTS (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .button         (button),
    .button_pressed (button_pressed),
    .press_pulse    (press_pulse),
    .release_pulse  (release_pulse)
  );

  // Rising edges at 10, 30, 50, ... ns.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Strobe tally, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (press_pulse)   press_cnt   = press_cnt + 1;
      if (release_pulse) release_cnt = release_cnt + 1;
    end
  end

  task automatic do_reset();
    button = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    button = 1'b1;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    checks = checks + 3;
    if (button_pressed !== 1'b0) begin failures++; $display("FAIL reset_pressed got=%b exp=0", button_pressed); end
    if (press_pulse !== 1'b0)    begin failures++; $display("FAIL reset_press_pulse got=%b exp=0", press_pulse); end
    if (release_pulse !== 1'b0)  begin failures++; $display("FAIL reset_release_pulse got=%b exp=0", release_pulse); end
    rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks = checks + 3;
      if (button_pressed !== (i >= 6)) begin failures++; $display("FAIL reset_hold_pressed edge=%0d got=%b exp=%b", i, button_pressed, (i >= 6)); end
      if (press_pulse !== (i == 6))    begin failures++; $display("FAIL reset_hold_press_pulse edge=%0d got=%b exp=%b", i, press_pulse, (i == 6)); end
      if (release_pulse !== 1'b0)      begin failures++; $display("FAIL reset_hold_release_pulse edge=%0d got=%b exp=0", i, release_pulse); end
    end
    $display("test_reset done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_clean_press();
    int p0;
    do_reset();
    p0 = press_cnt;
    @(posedge clk);
    #3 button = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks = checks + 3;
      if (button_pressed !== (i >= 6)) begin failures++; $display("FAIL press_pressed edge=%0d got=%b exp=%b", i, button_pressed, (i >= 6)); end
      if (press_pulse !== (i == 6))    begin failures++; $display("FAIL press_pulse edge=%0d got=%b exp=%b", i, press_pulse, (i == 6)); end
      if (release_pulse !== 1'b0)      begin failures++; $display("FAIL press_release_pulse edge=%0d got=%b exp=0", i, release_pulse); end
    end
    checks++;
    if (press_cnt - p0 !== 1) begin failures++; $display("FAIL press_pulse_count got=%0d exp=1", press_cnt - p0); end
    $display("test_clean_press done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_bounce();
    int r0;
    r0 = release_cnt;
    @(posedge clk);
    #3 button = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 button = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks = checks + 2;
      if (button_pressed !== 1'b1) begin failures++; $display("FAIL bounce_pressed cyc=%0d got=%b exp=1", i, button_pressed); end
      if (release_pulse !== 1'b0)  begin failures++; $display("FAIL bounce_release_pulse cyc=%0d got=%b exp=0", i, release_pulse); end
    end
    checks = checks + 2;
    if (dut.cnt_reg !== 2'd0)    begin failures++; $display("FAIL bounce_cnt got=%0d exp=0", dut.cnt_reg); end
    if (release_cnt - r0 !== 0)  begin failures++; $display("FAIL bounce_release_count got=%0d exp=0", release_cnt - r0); end
    $display("test_bounce done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_release();
    @(posedge clk);
    #3 button = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks = checks + 3;
      if (button_pressed !== (i < 6))  begin failures++; $display("FAIL release_pressed edge=%0d got=%b exp=%b", i, button_pressed, (i < 6)); end
      if (release_pulse !== (i == 6))  begin failures++; $display("FAIL release_pulse edge=%0d got=%b exp=%b", i, release_pulse, (i == 6)); end
      if (press_pulse !== 1'b0)        begin failures++; $display("FAIL release_press_pulse edge=%0d got=%b exp=0", i, press_pulse); end
    end
    $display("test_release done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_chatter();
    int p0;
    int r0;
    repeat (3) @(posedge clk);
    p0 = press_cnt;
    r0 = release_cnt;
    #3;
    for (int k = 0; k < 10; k++) begin
      button = ~button;
      #30;
    end
    checks = checks + 3;
    if (button_pressed !== 1'b0) begin failures++; $display("FAIL chatter_pressed got=%b exp=0", button_pressed); end
    if (press_cnt - p0 !== 0)    begin failures++; $display("FAIL chatter_press_count got=%0d exp=0", press_cnt - p0); end
    if (release_cnt - r0 !== 0)  begin failures++; $display("FAIL chatter_release_count got=%0d exp=0", release_cnt - r0); end
    repeat (3) @(posedge clk);
    #3 button = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks = checks + 2;
      if (button_pressed !== (i >= 6)) begin failures++; $display("FAIL chatter_hold_pressed edge=%0d got=%b exp=%b", i, button_pressed, (i >= 6)); end
      if (press_pulse !== (i == 6))    begin failures++; $display("FAIL chatter_hold_press_pulse edge=%0d got=%b exp=%b", i, press_pulse, (i == 6)); end
    end
    $display("test_chatter done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_mid_count_reset();
    int p0;
    int r0;
    @(posedge clk);
    #3 button = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks = checks + 2;
    if (dut.cnt_reg !== 2'd2)    begin failures++; $display("FAIL midreset_cnt_before got=%0d exp=2", dut.cnt_reg); end
    if (button_pressed !== 1'b1) begin failures++; $display("FAIL midreset_pressed_before got=%b exp=1", button_pressed); end
    #2 rst_n = 1'b0;
    #1;
    checks = checks + 4;
    if (dut.cnt_reg !== 2'd0)    begin failures++; $display("FAIL midreset_cnt got=%0d exp=0", dut.cnt_reg); end
    if (button_pressed !== 1'b0) begin failures++; $display("FAIL midreset_pressed got=%b exp=0", button_pressed); end
    if (press_pulse !== 1'b0)    begin failures++; $display("FAIL midreset_press_pulse got=%b exp=0", press_pulse); end
    if (release_pulse !== 1'b0)  begin failures++; $display("FAIL midreset_release_pulse got=%b exp=0", release_pulse); end
    repeat (2) @(negedge clk);
    p0 = press_cnt;
    r0 = release_cnt;
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    checks = checks + 3;
    if (button_pressed !== 1'b0) begin failures++; $display("FAIL midreset_after_pressed got=%b exp=0", button_pressed); end
    if (press_cnt - p0 !== 0)    begin failures++; $display("FAIL midreset_press_count got=%0d exp=0", press_cnt - p0); end
    if (release_cnt - r0 !== 0)  begin failures++; $display("FAIL midreset_release_count got=%0d exp=0", release_cnt - r0); end
    $display("test_mid_count_reset done: checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    press_cnt   = 0;
    release_cnt = 0;
    rst_n       = 1'b0;
    button      = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_chatter();
    test_mid_count_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=expired exp=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/button_debounce.md
# button_debounce

Debounces one mechanical push-button input for the game's control path. The raw, asynchronous button level is synchronised into the system clock domain. A clean level changes only after the synchronised input has held a new value for a programmable number of consecutive clock cycles. One-cycle press/release strobes are derived from that clean level for downstream game logic.

## Interface
- DELAY_COUNTS, default 1_000_000 (20 ms at 50 MHz): consecutive stable cycles required before the clean level changes; legal range ≥ 1.
- clk  input  1  system clock (50 MHz in the target design); all state on rising edge.
- rst_n  input  1  reset; asynchronous and active-low; clears all state.
- button  input  1  raw button level, asynchronous to clk, active-high, may bounce.
- button_pressed  output  1  debounced button level (registered).
- press_pulse  output  1  high for exactly one cycle when button_pressed goes 0→1 (registered).
- release_pulse  output  1  high for exactly one cycle when button_pressed goes 1→0 (registered).

## Operation
- Synchroniser: two flops in series, sync1 ← button, sync2 ← sync1; sync2 is the only internal view of the input.
- Counter cnt, width max(1, $clog2(DELAY_COUNTS)), unsigned.
- Each rising edge:
  - if sync2 == button_pressed: cnt ← 0 (any disagreement run is discarded).
  - else if cnt == DELAY_COUNTS-1: button_pressed ← sync2, cnt ← 0.
  - else: cnt ← cnt + 1.
- Result: output flips on the DELAY_COUNTS-th consecutive edge at which sync2 disagrees with button_pressed; a shorter disagreement run has no effect.
- DELAY_COUNTS = 1: output follows sync2 one cycle later.
- cnt never exceeds DELAY_COUNTS-1; no wrap-around possible.
- press_pulse ← sync2 & ~button_pressed & (cnt == DELAY_COUNTS-1), same edge button_pressed rises; release_pulse symmetrical. Both never high together.
- Reset (asserted any time, including mid-count): sync1, sync2, cnt, button_pressed, press_pulse, release_pulse all 0 immediately. A button held high through reset release is reported as a press after the normal latency.

## Timing
- Reset values: every output 0.
- Latency from a clean input edge to output change: 2 cycles (synchroniser) + DELAY_COUNTS cycles, ±1 cycle depending on input phase relative to clk.
- With DELAY_COUNTS = 4 and 20 ns clock, edges at 10, 30, 50, …: button rising at 23 ns gives sync1 = 1 at 30, sync2 = 1 at 50, cnt 1/2/3 at 70/90/110, button_pressed = 1 and press_pulse = 1 at 130, press_pulse = 0 at 150.
- A glitch visible in sync2 for fewer than DELAY_COUNTS consecutive edges is fully rejected.
- No handshake; strobes are not held and must be consumed in the cycle they appear.

## Structure
- No shared package needed; DELAY_COUNTS is a per-instance parameter; counter width is a derived localparam.
- One natural sub-module: sync_2ff (two-flop synchroniser, async active-low reset to 0), reusable for other board inputs.
- Top of this block holds counter, output register and strobe logic.

## Test plan
All scenarios use DELAY_COUNTS = 4 and a 20 ns clock.
- Reset: hold rst_n = 0 with button = 1 → all outputs 0; release rst_n → button_pressed = 1 exactly 6 edges later, press_pulse high for that one cycle.
- Clean press at 23 ns → button_pressed still 0 at 103 ns, 1 at 130 ns; press_pulse high only 130–150 ns.
- Bounce: after pressed = 1, drop button for 40 ns (2 cycles) then high → button_pressed stays 1, no release_pulse, cnt returns to 0.
- Release held 160 ns → button_pressed 1→0 after 2 + 4 edges, release_pulse one cycle.
- Chatter: toggle button every 30 ns for 300 ns → outputs unchanged; then hold high → press after normal latency.
- Mid-count reset: assert rst_n = 0 when cnt = 2 → cnt and outputs 0 immediately, no spurious pulse on release.
